// File: rtl/dclk_period_meter.sv
// ---------------------------------------------------------------------------
// dclk_period_meter
//
// Measures the period of a divided clock (dclk_i) in clk_i cycles and decodes
// it back to the power-of-two divider select code (256/128/64/32 -> 0/1/2/3).
// Each completed period is reported with a one-cycle valid_o pulse.
// Consecutive rising edges are measured back to back: the edge that closes
// one period also opens the next one.
//
// Optional feature: define DCLK_PERIOD_METER_DUTY_EN to also measure the
// high time of each period on high_o. Without the macro, high_o is tied to 0.
//
// Ports:
//   clk_i      in   1      system clock (single clock domain)
//   rst_i      in   1      synchronous reset, active-high
//   en_i       in   1      measurement enable
//   dclk_i     in   1      clock under measurement, asynchronous to clk_i
//   period_o   out  CNT_W  last measured period in clk_i cycles
//   sel_o      out  2      decoded select code of last measurement
//   match_o    out  1      last period was exactly 256/128/64/32
//   valid_o    out  1      one-cycle pulse: period_o/sel_o/match_o updated
//   timeout_o  out  1      sticky: no dclk_i edge within TIMEOUT_CYC cycles
//   high_o     out  CNT_W  high time of last period (optional feature)
// ---------------------------------------------------------------------------
module dclk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dclk_i,
    output logic [CNT_W-1:0] period_o,
    output logic [1:0]       sel_o,
    output logic             match_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] high_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    // Map a period to {match, sel}; anything off the power-of-two grid
    // reports sel 0 with no match.
    function automatic logic [2:0] decode_period(input logic [CNT_W-1:0] p);
        logic [2:0] res;
        case (p)
            CNT_W'(256): res = {1'b1, 2'd0};
            CNT_W'(128): res = {1'b1, 2'd1};
            CNT_W'(64):  res = {1'b1, 2'd2};
            CNT_W'(32):  res = {1'b1, 2'd3};
            default:     res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic             rise_s;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             meas_done_s;
    logic             tmo_hit_s;
    logic [CNT_W-1:0] period_r;
    logic [1:0]       sel_r;
    logic             match_r;
    logic             valid_r;
    logic             timeout_r;
    logic [2:0]       dec_s;

    // sync2/sync3 are both past the metastability stage, so their edge is
    // a clean one-cycle pulse; the fixed two-cycle delay cancels between
    // the opening and closing edge of a period.
    assign rise_s = sync2_r & ~sync3_r;
    assign dec_s  = decode_period(cnt_r);

    // Synchronizer chain for dclk_i; runs regardless of state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= dclk_i;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Next-state and period-counter logic. A rise takes priority over a
    // timeout landing in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        meas_done_s = 1'b0;
        tmo_hit_s   = 1'b0;
        if (!en_i) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_ARM;
                    cnt_nxt_s   = CNT_ZERO;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        state_nxt_s = ST_MEAS;
                        cnt_nxt_s   = CNT_ONE;
                    end else if (cnt_r >= TIMEOUT_V) begin
                        tmo_hit_s = 1'b1;
                        cnt_nxt_s = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_MEAS: begin
                    if (rise_s) begin
                        meas_done_s = 1'b1;
                        cnt_nxt_s   = CNT_ONE;
                    end else if (cnt_r >= TIMEOUT_V) begin
                        tmo_hit_s   = 1'b1;
                        state_nxt_s = ST_ARM;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and period counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Result registers: update on a completed period, hold otherwise.
    // timeout is sticky until the next good measurement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_r  <= CNT_ZERO;
            sel_r     <= 2'd0;
            match_r   <= 1'b0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            valid_r <= meas_done_s;
            if (meas_done_s) begin
                period_r  <= cnt_r;
                sel_r     <= dec_s[1:0];
                match_r   <= dec_s[2];
                timeout_r <= 1'b0;
            end else if (tmo_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign period_o  = period_r;
    assign sel_o     = sel_r;
    assign match_o   = match_r;
    assign valid_o   = valid_r;
    assign timeout_o = timeout_r;

`ifdef DCLK_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] hcnt_nxt_s;
    logic [CNT_W-1:0] high_r;

    // High-time counter: counts cycles with the delayed dclk high inside
    // the current period. The rise cycle itself always has sync3 low, so
    // restarting at 0 there loses nothing.
    always_comb begin
        hcnt_nxt_s = hcnt_r;
        if (!en_i || (state_r == ST_IDLE) || rise_s || tmo_hit_s) begin
            hcnt_nxt_s = CNT_ZERO;
        end else if (sync3_r && (hcnt_r != CNT_MAX)) begin
            hcnt_nxt_s = hcnt_r + CNT_ONE;
        end else begin
            hcnt_nxt_s = hcnt_r;
        end
    end

    // High-time counter and result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_r <= CNT_ZERO;
            high_r <= CNT_ZERO;
        end else begin
            hcnt_r <= hcnt_nxt_s;
            if (meas_done_s) begin
                high_r <= hcnt_r;
            end
        end
    end

    assign high_o = high_r;
`else
    assign high_o = CNT_ZERO;
`endif

endmodule
